// File: rtl/clock_regs_pkg.sv
// clock_regs_pkg: register map, CTRL/STATUS bit positions and load FSM encoding shared by clock_regs.
package clock_regs_pkg;
  localparam logic [7:0] ADDR_SET_SEC  = 8'h00;
  localparam logic [7:0] ADDR_SET_MIN  = 8'h01;
  localparam logic [7:0] ADDR_SET_HRS  = 8'h02;
  localparam logic [7:0] ADDR_CTRL     = 8'h03;
  localparam logic [7:0] ADDR_COLOR    = 8'h04;
  localparam logic [7:0] ADDR_STATUS   = 8'h05;
  localparam logic [7:0] ADDR_TIME_SEC = 8'h08;
  localparam logic [7:0] ADDR_TIME_MIN = 8'h09;
  localparam logic [7:0] ADDR_TIME_HRS = 8'h0A;
  localparam logic [7:0] ADDR_ID       = 8'h0F;
  localparam int CTRL_HALT = 0;
  localparam int CTRL_SYNC = 1;
  localparam int CTRL_LOAD = 2;
  localparam int STAT_BUSY = 0;
  localparam int STAT_ERR  = 1;
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT_TICK, ST_APPLY} state_e;
  typedef enum logic [1:0] {FLD_SEC, FLD_MIN, FLD_HRS} field_e;
endpackage

// File: rtl/bcd_time_check.sv
// bcd_time_check: combinational BCD range check for a seconds, minutes or hours value.
//   i_field  which time field the byte is destined for
//   i_data   packed BCD byte {tens, units}
//   o_valid  high when the byte is a legal value for that field
module bcd_time_check
  import clock_regs_pkg::*;
(
  input  field_e     i_field,
  input  logic [7:0] i_data,
  output logic       o_valid
);
  logic [3:0] w_units;
  logic [3:0] w_tens;
  assign w_units = i_data[3:0];
  assign w_tens  = i_data[7:4];
  // Hours top out at 23, so tens==2 further limits units to 0..3.
  assign o_valid = (w_units <= 4'd9) &&
                   ((i_field == FLD_HRS) ? ((w_tens < 4'd2) || (w_tens == 4'd2 && w_units <= 4'd3))
                                         : (w_tens <= 4'd5));
endmodule

// File: rtl/clock_regs.sv
// clock_regs: SPI command register bank holding time-set shadows, control bits and colour base.
//   clk, reset_n                       clock and asynchronous active-low reset
//   cmd_write/cmd_read/addr/wdata      one-cycle command strobes from cmdProc
//   sec_tick, cur_sec/min/hrs          timekeeper tick and live BCD time
//   rd_data, rd_valid                  registered read reply, valid 1 cycle after cmd_read
//   load_pulse, load_sec/min/hrs       atomic time load into the timekeeper
//   halt, color_base                   control outputs
module clock_regs
  import clock_regs_pkg::*;
#(
  parameter logic [7:0] ID_VALUE = 8'hC1,
  parameter int         COLOR_W  = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cmd_write,
  input  logic               cmd_read,
  input  logic [7:0]         cmd_addr,
  input  logic [7:0]         cmd_wdata,
  input  logic               sec_tick,
  input  logic [6:0]         cur_sec,
  input  logic [6:0]         cur_min,
  input  logic [5:0]         cur_hrs,
  output logic [7:0]         rd_data,
  output logic               rd_valid,
  output logic               load_pulse,
  output logic [6:0]         load_sec,
  output logic [6:0]         load_min,
  output logic [5:0]         load_hrs,
  output logic               halt,
  output logic [COLOR_W-1:0] color_base
);
  state_e             r_state;
  logic [6:0]         r_set_sec;
  logic [6:0]         r_set_min;
  logic [5:0]         r_set_hrs;
  logic [6:0]         r_snap_min;
  logic [5:0]         r_snap_hrs;
  logic               r_halt;
  logic               r_sync;
  logic               r_err;
  logic [COLOR_W-1:0] r_color;
  logic [7:0]         r_rd_data;
  logic               r_rd_valid;
  logic               r_load_pulse;
  logic [6:0]         r_load_sec;
  logic [6:0]         r_load_min;
  logic [5:0]         r_load_hrs;
  logic               w_busy;
  logic               w_set_wr;
  logic               w_bcd_ok;
  logic               w_set_ok;
  logic               w_ctrl_wr;
  logic               w_load_req;
  logic [7:0]         w_rd_mux;

  assign w_busy     = (r_state != ST_IDLE);
  assign w_set_wr   = cmd_write && (cmd_addr == ADDR_SET_SEC || cmd_addr == ADDR_SET_MIN || cmd_addr == ADDR_SET_HRS);
  assign w_set_ok   = w_set_wr && w_bcd_ok && !w_busy;
  assign w_ctrl_wr  = cmd_write && (cmd_addr == ADDR_CTRL);
  assign w_load_req = w_ctrl_wr && cmd_wdata[CTRL_LOAD];

  bcd_time_check u_check (
    .i_field (field_e'(cmd_addr[1:0])),
    .i_data  (cmd_wdata),
    .o_valid (w_bcd_ok)
  );

  always_comb begin
    w_rd_mux = 8'h00;
    case (cmd_addr)
      ADDR_SET_SEC:  w_rd_mux = {1'b0, r_set_sec};
      ADDR_SET_MIN:  w_rd_mux = {1'b0, r_set_min};
      ADDR_SET_HRS:  w_rd_mux = {2'b00, r_set_hrs};
      ADDR_CTRL:     w_rd_mux = {6'b0, r_sync, r_halt};
      ADDR_COLOR:    w_rd_mux = 8'(r_color);
      ADDR_STATUS:   w_rd_mux = {6'b0, r_err, w_busy};
      ADDR_TIME_SEC: w_rd_mux = {1'b0, cur_sec};
      ADDR_TIME_MIN: w_rd_mux = {1'b0, r_snap_min};
      ADDR_TIME_HRS: w_rd_mux = {2'b00, r_snap_hrs};
      ADDR_ID:       w_rd_mux = ID_VALUE;
      default:       w_rd_mux = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_set_sec  <= '0;
      r_set_min  <= '0;
      r_set_hrs  <= '0;
      r_snap_min <= '0;
      r_snap_hrs <= '0;
      r_halt     <= 1'b0;
      r_sync     <= 1'b0;
      r_err      <= 1'b0;
      r_color    <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      if (w_set_ok && cmd_addr == ADDR_SET_SEC) r_set_sec <= cmd_wdata[6:0];
      if (w_set_ok && cmd_addr == ADDR_SET_MIN) r_set_min <= cmd_wdata[6:0];
      if (w_set_ok && cmd_addr == ADDR_SET_HRS) r_set_hrs <= cmd_wdata[5:0];
      if (w_set_wr && !w_set_ok) r_err <= 1'b1;
      else if (cmd_write && cmd_addr == ADDR_STATUS && cmd_wdata[STAT_ERR]) r_err <= 1'b0;
      if (w_ctrl_wr) begin
        r_halt <= cmd_wdata[CTRL_HALT];
        r_sync <= cmd_wdata[CTRL_SYNC];
      end
      if (cmd_write && cmd_addr == ADDR_COLOR) r_color <= cmd_wdata[COLOR_W-1:0];
      r_rd_valid <= cmd_read;
      if (cmd_read) r_rd_data <= w_rd_mux;
      // Reading TIME_SEC freezes min/hrs so the following reads form one coherent time.
      if (cmd_read && cmd_addr == ADDR_TIME_SEC) begin
        r_snap_min <= cur_min;
        r_snap_hrs <= cur_hrs;
      end
    end
  end

  // Load outputs are registered on entry to APPLY so load_pulse is high exactly in the APPLY cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_load_pulse <= 1'b0;
      r_load_sec   <= '0;
      r_load_min   <= '0;
      r_load_hrs   <= '0;
    end else begin
      r_load_pulse <= 1'b0;
      case (r_state)
        ST_IDLE: if (w_load_req) begin
          r_state <= cmd_wdata[CTRL_SYNC] ? ST_WAIT_TICK : ST_APPLY;
          if (!cmd_wdata[CTRL_SYNC]) begin
            r_load_pulse <= 1'b1;
            r_load_sec   <= r_set_sec;
            r_load_min   <= r_set_min;
            r_load_hrs   <= r_set_hrs;
          end
        end
        ST_WAIT_TICK: if (sec_tick) begin
          r_state      <= ST_APPLY;
          r_load_pulse <= 1'b1;
          r_load_sec   <= r_set_sec;
          r_load_min   <= r_set_min;
          r_load_hrs   <= r_set_hrs;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign rd_data    = r_rd_data;
  assign rd_valid   = r_rd_valid;
  assign load_pulse = r_load_pulse;
  assign load_sec   = r_load_sec;
  assign load_min   = r_load_min;
  assign load_hrs   = r_load_hrs;
  assign halt       = r_halt;
  assign color_base = r_color;
endmodule
